// File: rtl/branch_predictor_unit.sv
// Dynamic branch predictor: direct-mapped BTB with 2-bit counters for fetch lookup,
// plus decode-side resolve/redirect and table training.
module branch_predictor_unit #(
    parameter int          XLEN           = 32,
    parameter int          ENTRIES        = 16,
    parameter int          IDX_BITS       = $clog2(ENTRIES),
    parameter int          TAG_BITS       = XLEN - IDX_BITS - 2,
    parameter logic [1:0]  CNT_INIT_TAKEN = 2'b10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pcF,
    output logic            predTakenF,
    output logic [XLEN-1:0] predTargetF,
    input  logic            brValidD,
    input  logic            isJumpD,
    input  logic            stallD,
    input  logic [XLEN-1:0] pcD,
    input  logic            predTakenD,
    input  logic [XLEN-1:0] predTargetD,
    input  logic            actTakenD,
    input  logic [XLEN-1:0] actTargetD,
    output logic            FlushD,
    output logic            redirectValid,
    output logic [XLEN-1:0] redirectPC,
    output logic [31:0]     branchCount,
    output logic [31:0]     mispredCount
);

    logic [IDX_BITS-1:0] f_idx, d_idx;
    logic [TAG_BITS-1:0] f_tag, d_tag;
    logic                resolve_en;
    logic                mispredict;
    logic                unused_pc_bits;

    logic                ent_valid  [ENTRIES];
    logic [TAG_BITS-1:0] ent_tag    [ENTRIES];
    logic [XLEN-1:0]     ent_target [ENTRIES];
    logic [1:0]          ent_cnt    [ENTRIES];
    logic                ent_jump   [ENTRIES];

    logic [31:0] branch_count_reg;
    logic [31:0] mispred_count_reg;

    assign f_idx = pcF[IDX_BITS+1:2];
    assign f_tag = pcF[XLEN-1:IDX_BITS+2];
    assign d_idx = pcD[IDX_BITS+1:2];
    assign d_tag = pcD[XLEN-1:IDX_BITS+2];
    assign unused_pc_bits = ^{pcF[1:0], pcD[1:0]};

    assign resolve_en = brValidD & ~stallD & ~reset;

    // Each entry owns its registers; only the entry addressed by pcD trains.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic                valid_reg;
            logic [TAG_BITS-1:0] tag_reg;
            logic [XLEN-1:0]     target_reg;
            logic [1:0]          cnt_reg;
            logic                jump_reg;
            logic                sel;
            logic                hit;

            assign sel = resolve_en && (d_idx == IDX_BITS'(gi));
            assign hit = valid_reg && (tag_reg == d_tag);

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_reg  <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                    cnt_reg    <= 2'b01;
                    jump_reg   <= 1'b0;
                end else if (sel) begin
                    if (hit) begin
                        if (actTakenD) begin
                            if (cnt_reg != 2'b11) cnt_reg <= cnt_reg + 2'b01;
                            target_reg <= actTargetD;
                        end else if (cnt_reg != 2'b00) begin
                            cnt_reg <= cnt_reg - 2'b01;
                        end
                        jump_reg <= isJumpD;
                    end else if (actTakenD) begin
                        valid_reg  <= 1'b1;
                        tag_reg    <= d_tag;
                        target_reg <= actTargetD;
                        jump_reg   <= isJumpD;
                        cnt_reg    <= isJumpD ? 2'b11 : CNT_INIT_TAKEN;
                    end
                end
            end

            assign ent_valid[gi]  = valid_reg;
            assign ent_tag[gi]    = tag_reg;
            assign ent_target[gi] = target_reg;
            assign ent_cnt[gi]    = cnt_reg;
            assign ent_jump[gi]   = jump_reg;
        end
    endgenerate

    // Lookup sees pre-update contents; there is deliberately no bypass from decode.
    always_comb begin
        predTakenF  = 1'b0;
        predTargetF = '0;
        if (!reset && ent_valid[f_idx] && (ent_tag[f_idx] == f_tag)
                && (ent_jump[f_idx] || ent_cnt[f_idx][1])) begin
            predTakenF  = 1'b1;
            predTargetF = ent_target[f_idx];
        end
    end

    always_comb begin
        mispredict    = 1'b0;
        FlushD        = 1'b0;
        redirectValid = 1'b0;
        redirectPC    = '0;
        if (resolve_en) begin
            if (predTakenD && !actTakenD) begin
                mispredict = 1'b1;
                redirectPC = pcD + XLEN'(4);
            end else if (actTakenD && (!predTakenD || (predTargetD != actTargetD))) begin
                mispredict = 1'b1;
                redirectPC = actTargetD;
            end
            FlushD        = mispredict;
            redirectValid = mispredict;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count_reg  <= '0;
            mispred_count_reg <= '0;
        end else if (resolve_en) begin
            branch_count_reg  <= branch_count_reg + 32'd1;
            mispred_count_reg <= mispred_count_reg + {31'b0, mispredict};
        end
    end

    assign branchCount  = branch_count_reg;
    assign mispredCount = mispred_count_reg;

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Directed bench for branch_predictor_unit: lookup, resolve, training, stall and reset.
module tb_branch_predictor_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pcF;
    logic        predTakenF;
    logic [31:0] predTargetF;
    logic        brValidD, isJumpD, stallD, predTakenD, actTakenD;
    logic [31:0] pcD, predTargetD, actTargetD;
    logic        FlushD, redirectValid;
    logic [31:0] redirectPC, branchCount, mispredCount;

    int checks = 0;
    int passed = 0;

    branch_predictor_unit dut (
        .clk(clk), .reset(reset), .pcF(pcF),
        .predTakenF(predTakenF), .predTargetF(predTargetF),
        .brValidD(brValidD), .isJumpD(isJumpD), .stallD(stallD), .pcD(pcD),
        .predTakenD(predTakenD), .predTargetD(predTargetD),
        .actTakenD(actTakenD), .actTargetD(actTargetD),
        .FlushD(FlushD), .redirectValid(redirectValid), .redirectPC(redirectPC),
        .branchCount(branchCount), .mispredCount(mispredCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        $display("check %-18s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                           input logic at, input logic [31:0] atgt, input logic jmp);
        brValidD = 1'b1; pcD = pc; predTakenD = pt; predTargetD = ptgt;
        actTakenD = at; actTargetD = atgt; isJumpD = jmp;
        #1;
    endtask

    task automatic idle();
        brValidD = 1'b0; predTakenD = 1'b0; actTakenD = 1'b0; isJumpD = 1'b0;
        #1;
    endtask

    task automatic look(input logic [31:0] pc);
        pcF = pc;
        #1;
    endtask

    initial begin
        reset = 1'b1; pcF = '0; brValidD = 0; isJumpD = 0; stallD = 0; pcD = '0;
        predTakenD = 0; predTargetD = '0; actTakenD = 0; actTargetD = '0;
        tick(); tick();

        // Reset: outputs gated, and the pending update is discarded
        look(32'h100);
        resolve(32'h100, 0, 0, 1, 32'h80, 0);
        chk("rst_flush", {31'b0, FlushD}, 0);
        chk("rst_redir", {31'b0, redirectValid}, 0);
        tick();
        reset = 1'b0; idle();
        chk("rst_bcnt", branchCount, 0);
        chk("rst_mcnt", mispredCount, 0);
        chk("rst_pred", {31'b0, predTakenF}, 0);
        chk("rst_tgt", predTargetF, 0);

        // 1: not-predicted taken branch allocates with counter 2
        resolve(32'h100, 0, 0, 1, 32'h80, 0);
        chk("t1_flush", {31'b0, FlushD}, 1);
        chk("t1_redirv", {31'b0, redirectValid}, 1);
        chk("t1_redpc", redirectPC, 32'h80);
        chk("t1_same_cyc", {31'b0, predTakenF}, 0);
        tick(); idle();
        chk("t1_pred", {31'b0, predTakenF}, 1);
        chk("t1_tgt", predTargetF, 32'h80);
        chk("t1_bcnt", branchCount, 1);
        chk("t1_mcnt", mispredCount, 1);

        // 2: not-taken training and saturation at 0
        resolve(32'h100, 1, 32'h80, 0, 32'h80, 0);
        chk("t2_flush", {31'b0, FlushD}, 1);
        chk("t2_redpc", redirectPC, 32'h104);
        tick(); idle();
        chk("t2_pred_c1", {31'b0, predTakenF}, 0);
        chk("t2_tgt_c1", predTargetF, 0);
        resolve(32'h100, 0, 0, 0, 32'h80, 0);
        chk("t2_noflush", {31'b0, FlushD}, 0);
        chk("t2_noredpc", redirectPC, 0);
        tick(); tick(); tick(); idle();
        chk("t2_bcnt", branchCount, 5);
        chk("t2_mcnt", mispredCount, 2);
        resolve(32'h100, 0, 0, 1, 32'h80, 0);
        tick(); idle();
        chk("t2_sat_c1", {31'b0, predTakenF}, 0);
        resolve(32'h100, 0, 0, 1, 32'h90, 0);
        tick(); idle();
        chk("t2_c2_pred", {31'b0, predTakenF}, 1);
        chk("t2_c2_tgt", predTargetF, 32'h90);
        chk("t2_mcnt2", mispredCount, 4);

        // 3: JAL allocates strongly taken, JALR retargets
        resolve(32'h200, 0, 0, 1, 32'h400, 1);
        chk("t3_jal_redpc", redirectPC, 32'h400);
        tick(); idle(); look(32'h200);
        chk("t3_jal_pred", {31'b0, predTakenF}, 1);
        chk("t3_jal_tgt", predTargetF, 32'h400);
        resolve(32'h200, 1, 32'h400, 1, 32'h500, 1);
        chk("t3_jalr_flush", {31'b0, FlushD}, 1);
        chk("t3_jalr_redpc", redirectPC, 32'h500);
        tick(); idle();
        chk("t3_jalr_tgt", predTargetF, 32'h500);
        resolve(32'h200, 1, 32'h500, 1, 32'h500, 1);
        chk("t3_correct", {31'b0, FlushD}, 0);
        tick(); idle();
        chk("t3_bcnt", branchCount, 10);
        chk("t3_mcnt", mispredCount, 6);

        // 4: aliasing on index 0 replaces the older entry
        resolve(32'h40, 0, 0, 1, 32'h1000, 0);
        tick();
        resolve(32'h80, 0, 0, 1, 32'h2000, 0);
        look(32'h40);
        chk("t4_pre_pred", {31'b0, predTakenF}, 1);
        chk("t4_pre_tgt", predTargetF, 32'h1000);
        tick(); idle();
        chk("t4_evicted", {31'b0, predTakenF}, 0);
        look(32'h80);
        chk("t4_new_pred", {31'b0, predTakenF}, 1);
        chk("t4_new_tgt", predTargetF, 32'h2000);

        // 5: stall suppresses resolve and update; release resolves once
        stallD = 1'b1;
        resolve(32'h300, 0, 0, 1, 32'h600, 0);
        chk("t5_stall_flush", {31'b0, FlushD}, 0);
        chk("t5_stall_redir", {31'b0, redirectValid}, 0);
        tick(); tick(); tick();
        look(32'h300);
        chk("t5_stall_bcnt", branchCount, 12);
        chk("t5_stall_mcnt", mispredCount, 8);
        chk("t5_stall_pred", {31'b0, predTakenF}, 0);
        stallD = 1'b0; #1;
        chk("t5_rel_flush", {31'b0, FlushD}, 1);
        chk("t5_rel_redpc", redirectPC, 32'h600);
        tick(); idle();
        chk("t5_bcnt", branchCount, 13);
        chk("t5_mcnt", mispredCount, 9);
        chk("t5_pred", {31'b0, predTakenF}, 1);

        // 6: pcD+4 wraps; reset during a valid update clears everything
        resolve(32'hFFFF_FFFC, 0, 0, 1, 32'h8, 0);
        tick(); idle(); look(32'hFFFF_FFFC);
        chk("t6_pred", {31'b0, predTakenF}, 1);
        resolve(32'hFFFF_FFFC, 1, 32'h8, 0, 32'h8, 0);
        chk("t6_flush", {31'b0, FlushD}, 1);
        chk("t6_wrap_redpc", redirectPC, 32'h0);
        tick();
        resolve(32'h500, 0, 0, 1, 32'h700, 0);
        chk("t6_mcnt", mispredCount, 11);
        reset = 1'b1; #1;
        chk("t6_rst_flush", {31'b0, FlushD}, 0);
        tick();
        reset = 1'b0; idle();
        chk("t6_rst_old", {31'b0, predTakenF}, 0);
        look(32'h500);
        chk("t6_rst_new", {31'b0, predTakenF}, 0);
        chk("t6_rst_bcnt", branchCount, 0);
        chk("t6_rst_mcnt", mispredCount, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_predictor_unit.md
Name: branch_predictor_unit

Overview:
Parametrised dynamic branch predictor with resolve/redirect logic. It is the successor to the static decode-stage branch resolver.
- Fetch side: a direct-mapped branch target buffer (BTB) with 2-bit saturating counters gives a predicted next PC.
- Decode side: compares the prediction against the resolved outcome, issues flush/redirect on mispredict, and trains the table.
- Sits between the PC-select mux in IF and the branch comparator in ID.

Parameters:
XLEN, 32, datapath/PC width
ENTRIES, 16, BTB entries; power of two, >=2
IDX_BITS, $clog2(ENTRIES), index width; index = pc[IDX_BITS+1:2]
TAG_BITS, XLEN-IDX_BITS-2, tag width; tag = pc[XLEN-1:IDX_BITS+2]
CNT_INIT_TAKEN, 2'b10, counter value written when allocating a taken branch

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
pcF  in  XLEN  fetch-stage PC to look up
predTakenF  out  1  fetch prediction: take predTargetF
predTargetF  out  XLEN  predicted target; 0 when predTakenF=0
brValidD  in  1  decode instruction is a conditional branch or jump
isJumpD  in  1  decode instruction is JAL/JALR (unconditional)
stallD  in  1  decode stalled; suppresses resolve and update
pcD  in  XLEN  decode-stage PC
predTakenD  in  1  predTakenF piped into decode
predTargetD  in  XLEN  predTargetF piped into decode
actTakenD  in  1  resolved direction (forced 1 when isJumpD)
actTargetD  in  XLEN  resolved target address
FlushD  out  1  flush IF/ID register (mispredict)
redirectValid  out  1  PC mux must select redirectPC
redirectPC  out  XLEN  corrected next PC
branchCount  out  32  resolved branch/jump count
mispredCount  out  32  mispredict count

Behaviour:
- Storage per entry: valid (1), tag (TAG_BITS), target (XLEN), counter (2), jump flag (1). Registers only, no SRAM.
- Reset, synchronous: all valid=0, counters=2'b01, targets/tags=0, branchCount=mispredCount=0. Combinational outputs are 0 while reset=1.
- Lookup (combinational from pcF):
  - hit = valid & tag match.
  - predTakenF = hit & (jump | counter[1]).
  - predTargetF = stored target when predTakenF, else 0.
- Resolve (combinational; gated by resolveEn = brValidD & ~stallD & ~reset). Mispredict when any of:
  - predTakenD=1 & actTakenD=0 → redirectPC = pcD+4
  - predTakenD=0 & actTakenD=1 → redirectPC = actTargetD
  - predTakenD=1 & actTakenD=1 & predTargetD != actTargetD → redirectPC = actTargetD
- On mispredict: FlushD = redirectValid = 1. Otherwise all three resolve outputs are 0. They are 0 when resolveEn=0.
- PC arithmetic is modulo 2^XLEN; pcD+4 wraps.
- Update (rising edge, when resolveEn) at index/tag of pcD:
  - Hit: counter saturating +1 if actTakenD, -1 if not (3 stays 3, 0 stays 0). Target overwritten with actTargetD if actTakenD. Jump flag = isJumpD.
  - Miss & actTakenD: allocate/replace entry; valid=1, tag, target=actTargetD, jump=isJumpD, counter = isJumpD ? 2'b11 : CNT_INIT_TAKEN.
  - Miss & ~actTakenD: no allocation, table unchanged.
- Same-cycle lookup and update of the same index: lookup returns the pre-update contents. The new contents are visible from the next cycle. No write-through bypass.
- Counters (rising edge, when resolveEn): branchCount+1; mispredCount+1 if mispredict. Both wrap at 2^32.
- stallD=1 holds the table and counters unchanged. The instruction re-resolves when the stall releases, so each instruction is counted exactly once.
- Reset asserted mid-stream overrides any pending update in that cycle.
- Latency: prediction 0 cycles (same-cycle lookup); redirect 0 cycles after decode inputs; training visible 1 cycle after the update edge.

Test Plan:
1. Reset, then pcF=0x100 → predTakenF=0, predTargetF=0. Branch at pcD=0x100, predTakenD=0, actTakenD=1, actTargetD=0x80 → FlushD=1, redirectPC=0x80. Next cycle pcF=0x100 → predTakenF=1, predTargetF=0x80. Counter=2.
2. Same branch resolved not-taken twice → first: FlushD=1, redirectPC=0x104, counter=1. Second: predTakenF=0, no flush, counter=0. Two more not-taken leave counter at 0 (saturation). mispredCount increments only on the first.
3. JAL at pcD=0x200, target 0x400, miss → allocated with counter=3. Later JALR at 0x200 with actTargetD=0x500 while predicted 0x400 → FlushD=1, redirectPC=0x500, entry target becomes 0x500.
4. ENTRIES=16: taken branches at 0x40 and 0x80 (same index 0) → second replaces first. pcF=0x40 then misses (predTakenF=0).
5. stallD=1 with a mispredicting branch for 3 cycles → FlushD=0, counts unchanged. Release stall → one flush; branchCount+1, mispredCount+1.
6. Wrap/boundary: pcD=0xFFFFFFFC predicted taken, resolved not-taken → redirectPC=0x00000000. Assert reset during a valid update → table stays cleared.
